axilite_csr_write_engine: RTL and testbench

AXILITE_CSR_WRITE_ENGINE -- requirements
Module: axilite_csr_write_engine

---
 rtl/axilite_csr_write_engine_if.sv | 30 +++
 rtl/axilite_csr_write_engine.sv | 217 +++++++++++++++++++++
 tb/tb_axilite_csr_write_engine.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_csr_write_engine_if.sv
// AXI4-Lite write-path bundle (AW, W, B channels) between a bus master and
// the CSR write engine. Handshake rule on every channel: a transfer happens
// on a rising clock edge where both valid and ready are 1; the sender keeps
// its payload and valid stable until that edge, and ready may be raised or
// lowered freely by the receiver.
interface axilite_csr_write_engine_if #(
   parameter int ADDR_SIZE  = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_SIZE-1:0]      awaddr;
   logic                      awvalid;
   logic                      awready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wvalid;
   logic                      wready;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axilite_csr_write_engine.sv
// AXI4-Lite write-only CSR block. AW and W may arrive in either order or
// together; the write commits on the edge that completes the second of the
// two handshakes, and the B response is presented from the following cycle.
// Each register is RW, RO (mirrors ro_in), W1C (sticky hw_set, write-1 clear,
// set wins) or W1P (reads 0, write-1 produces a one-cycle pulse).
module axilite_csr_write_engine #(
   parameter int                            NUM_REGS      = 4,
   parameter int                            DATA_WIDTH    = 32,
   parameter int                            ADDR_SIZE     = 32,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] INITIAL_VALUE = '0,
   parameter logic [NUM_REGS-1:0]           RO_MASK       = '0,
   parameter logic [NUM_REGS-1:0]           W1C_MASK      = '0,
   parameter logic [NUM_REGS-1:0]           W1P_MASK      = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   axilite_csr_write_engine_if.slave        bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   regs,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   ro_in,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_set,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   pulse,
   output logic [NUM_REGS-1:0]              wr_stb,
   output logic [1:0]                       fsm_state
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = (STRB_W > 1) ? $clog2(STRB_W) : 0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_W  = 2'd1,
      WAIT_AW = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_SIZE-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic [1:0]              bresp_q;
   logic [NUM_REGS-1:0]     wr_stb_q;

   logic                    aw_fire;
   logic                    w_fire;
   logic                    commit;
   logic [ADDR_SIZE-1:0]    cm_addr;
   logic [DATA_WIDTH-1:0]   cm_data;
   logic [STRB_W-1:0]       cm_strb;
   logic [ADDR_SIZE-1:0]    cm_idx;
   logic [NUM_REGS-1:0]     cm_sel;
   logic                    cm_ok;
   logic [DATA_WIDTH-1:0]   cm_mask;
   logic [DATA_WIDTH-1:0]   cm_bits;
   logic [NUM_REGS-1:0]     wr_en;

   // Channel readiness is a pure function of state: no input-to-output paths.
   assign bus.awready = (state_q == IDLE) || (state_q == WAIT_AW);
   assign bus.wready  = (state_q == IDLE) || (state_q == WAIT_W);
   assign bus.bvalid  = (state_q == RESP);
   assign bus.bresp   = bresp_q;
   assign fsm_state   = state_q;
   assign wr_stb      = wr_stb_q;

   assign aw_fire = bus.awvalid && bus.awready;
   assign w_fire  = bus.wvalid && bus.wready;

   // Pick the committing address/data: live bus values for the channel that
   // completes now, captured values for the channel that completed earlier.
   always_comb begin
      commit  = 1'b0;
      cm_addr = addr_q;
      cm_data = wdata_q;
      cm_strb = wstrb_q;
      case (state_q)
         IDLE: begin
            cm_addr = bus.awaddr;
            cm_data = bus.wdata;
            cm_strb = bus.wstrb;
            commit  = aw_fire && w_fire;
         end
         WAIT_W: begin
            cm_data = bus.wdata;
            cm_strb = bus.wstrb;
            commit  = w_fire;
         end
         WAIT_AW: begin
            cm_addr = bus.awaddr;
            commit  = aw_fire;
         end
         default: begin
            commit  = 1'b0;
         end
      endcase
   end

   // Decode the register index (byte offset bits dropped) and byte-lane mask.
   always_comb begin
      cm_idx = cm_addr >> LSB;
      cm_sel = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (cm_idx == ADDR_SIZE'(k)) begin
            cm_sel[k] = 1'b1;
         end
      end
      cm_ok = (|cm_sel) && !(|(cm_sel & RO_MASK));
      for (int b = 0; b < STRB_W; b++) begin
         cm_mask[b*8 +: 8] = {8{cm_strb[b]}};
      end
      cm_bits = cm_data & cm_mask;
   end

   assign wr_en = {NUM_REGS{commit && cm_ok}} & cm_sel;

   // Next-state logic and capture of whichever channel arrives first.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      case (state_q)
         IDLE: begin
            if (aw_fire && w_fire) begin
               state_d = RESP;
            end else if (aw_fire) begin
               addr_d  = bus.awaddr;
               state_d = WAIT_W;
            end else if (w_fire) begin
               wdata_d = bus.wdata;
               wstrb_d = bus.wstrb;
               state_d = WAIT_AW;
            end
         end
         WAIT_W: begin
            if (w_fire) begin
               state_d = RESP;
            end
         end
         WAIT_AW: begin
            if (aw_fire) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.bready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, capture registers, response code and write strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         wr_stb_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         wr_stb_q <= wr_en;
         if (commit) begin
            bresp_q <= cm_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_q, reg_d;
      logic [DATA_WIDTH-1:0] pulse_q, pulse_d;

      // Per-register update rule selected by the mode masks (RO has priority).
      always_comb begin
         reg_d   = reg_q;
         pulse_d = '0;
         if (RO_MASK[k]) begin
            reg_d = ro_in[k*DATA_WIDTH +: DATA_WIDTH];
         end else if (W1P_MASK[k]) begin
            reg_d = '0;
            if (wr_en[k]) begin
               pulse_d = cm_bits;
            end
         end else if (W1C_MASK[k]) begin
            // Clear first, then OR in hardware sets so a coincident set wins.
            reg_d = (reg_q & ~(wr_en[k] ? cm_bits : '0))
                    | hw_set[k*DATA_WIDTH +: DATA_WIDTH];
         end else if (wr_en[k]) begin
            reg_d = (reg_q & ~cm_mask) | cm_bits;
         end
      end

      // Register storage and pulse output; W1P registers always hold zero.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            reg_q   <= W1P_MASK[k] ? '0 : INITIAL_VALUE[k*DATA_WIDTH +: DATA_WIDTH];
            pulse_q <= '0;
         end else begin
            reg_q   <= reg_d;
            pulse_q <= pulse_d;
         end
      end

      assign regs[k*DATA_WIDTH +: DATA_WIDTH]  = reg_q;
      assign pulse[k*DATA_WIDTH +: DATA_WIDTH] = pulse_q;
   end

endmodule

// File: tb/tb_axilite_csr_write_engine.sv
// Directed bench for the CSR write engine: a transaction-level model driven
// by the same inputs is compared against the DUT on every falling edge, and
// directed scenarios pin the model with hand-computed literals.
module tb_axilite_csr_write_engine;

   localparam logic [127:0] INIT = {32'h33333333, 32'hAAAA5555, 32'h000000F0, 32'h11111111};
   localparam logic [3:0]   RO   = 4'b0100;
   localparam logic [3:0]   W1C  = 4'b0010;
   localparam logic [3:0]   W1P  = 4'b1000;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   axilite_csr_write_engine_if #(.ADDR_SIZE(32), .DATA_WIDTH(32)) bus ();

   logic [127:0] regs;
   logic [127:0] ro_in;
   logic [127:0] hw_set;
   logic [127:0] pulse;
   logic [3:0]   wr_stb;
   logic [1:0]   fsm_state;

   axilite_csr_write_engine #(
      .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_SIZE(32),
      .INITIAL_VALUE(INIT), .RO_MASK(RO), .W1C_MASK(W1C), .W1P_MASK(W1P)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .regs(regs), .ro_in(ro_in), .hw_set(hw_set),
      .pulse(pulse), .wr_stb(wr_stb), .fsm_state(fsm_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] m_regs [4];
   logic [31:0] m_pulse[4];
   logic [3:0]  m_stb;
   bit          m_aw_have, m_w_have, m_b_out;
   logic [31:0] m_addr, m_data;
   logic [3:0]  m_strb;
   logic [1:0]  m_resp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_regs[k]  = W1P[k] ? 32'h0 : INIT[k*32 +: 32];
            m_pulse[k] = 32'h0;
         end
         m_stb = 4'h0; m_aw_have = 0; m_w_have = 0; m_b_out = 0; m_resp = 2'b00;
      end else begin
         bit aw_acc, w_acc;
         logic [31:0] idx, mask, bits;
         aw_acc = bus.awvalid && !m_aw_have && !m_b_out;
         w_acc  = bus.wvalid && !m_w_have && !m_b_out;
         if (m_b_out && bus.bready) m_b_out = 0;
         for (int k = 0; k < 4; k++) m_pulse[k] = 32'h0;
         m_stb = 4'h0;
         if (aw_acc) begin m_aw_have = 1; m_addr = bus.awaddr; end
         if (w_acc) begin m_w_have = 1; m_data = bus.wdata; m_strb = bus.wstrb; end
         if (m_aw_have && m_w_have) begin
            idx = m_addr / 4;
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = m_strb[b] ? 8'hFF : 8'h00;
            bits = m_data & mask;
            if (idx >= 4 || RO[idx[1:0]]) begin
               m_resp = 2'b10;
            end else begin
               m_resp = 2'b00;
               m_stb[idx[1:0]] = 1'b1;
               if (W1P[idx[1:0]])      m_pulse[idx[1:0]] = bits;
               else if (W1C[idx[1:0]]) m_regs[idx[1:0]] = m_regs[idx[1:0]] & ~bits;
               else                    m_regs[idx[1:0]] = (m_regs[idx[1:0]] & ~mask) | bits;
            end
            m_aw_have = 0; m_w_have = 0; m_b_out = 1;
         end
         for (int k = 0; k < 4; k++) begin
            if (RO[k])  m_regs[k] = ro_in[k*32 +: 32];
            if (W1C[k]) m_regs[k] = m_regs[k] | hw_set[k*32 +: 32];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [1:0] exp_state;
      exp_state = m_b_out ? 2'd3 : m_aw_have ? 2'd1 : m_w_have ? 2'd2 : 2'd0;
      check("regs",    regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      check("pulse",   pulse, {m_pulse[3], m_pulse[2], m_pulse[1], m_pulse[0]});
      check("wr_stb",  128'(wr_stb), 128'(m_stb));
      check("awready", 128'(bus.awready), 128'(!m_aw_have && !m_b_out));
      check("wready",  128'(bus.wready), 128'(!m_w_have && !m_b_out));
      check("bvalid",  128'(bus.bvalid), 128'(m_b_out));
      check("state",   128'(fsm_state), 128'(exp_state));
      if (m_b_out) check("bresp", 128'(bus.bresp), 128'(m_resp));
      if (rst)     check("bresp_rst", 128'(bus.bresp), 128'(2'b00));
   end

   // ---------------- driver ----------------
   logic [127:0] r_regs, r_pulse, r_pulse2;
   logic [3:0]   r_stb;
   logic [1:0]   r_resp;
   logic [1:0]   mid_state;
   int           b_cycles;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done, w_done, aw_f, w_f, b_f;
      int t, bc, mid_t;
      aw_done = 0; w_done = 0; t = 0;
      mid_t = (aw_dly > w_dly) ? aw_dly : w_dly;
      mid_state = 2'd0;
      while (!(aw_done && w_done) && t < 40) begin
         @(negedge clk);
         bus.awvalid = !aw_done && (t >= aw_dly);
         bus.awaddr  = a;
         bus.wvalid  = !w_done && (t >= w_dly);
         bus.wdata   = d;
         bus.wstrb   = s;
         bus.bready  = 1'b0;
         if (t == mid_t) mid_state = fsm_state;
         aw_f = bus.awvalid && bus.awready;
         w_f  = bus.wvalid && bus.wready;
         @(posedge clk);
         if (aw_f) aw_done = 1;
         if (w_f)  w_done = 1;
         t++;
      end
      if (!(aw_done && w_done)) check("hs_timeout", 128'({aw_done, w_done}), 128'(2'b11));
      bc = 0; b_f = 0; t = 0; r_pulse2 = '0;
      while (!b_f && t < 40) begin
         @(negedge clk);
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
         bus.bready  = (t >= b_dly);
         if (bus.bvalid) begin
            if (bc == 0) begin
               r_regs = regs; r_pulse = pulse; r_stb = wr_stb; r_resp = bus.bresp;
            end
            if (bc == 1) r_pulse2 = pulse;
            bc++;
            b_f = bus.bready;
         end
         t++;
      end
      if (!b_f) check("b_timeout", 128'(b_f), 128'(1'b1));
      b_cycles = bc;
      @(negedge clk);
      bus.bready = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      rst = 1'b1;
      bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 0; bus.bready = 0;
      ro_in  = {32'h5A5A5A5A, 32'hCAFE0002, 32'h5A5A5A5A, 32'h5A5A5A5A};
      hw_set = '0;
      idle(3);
      check("rst_regs",    regs, 128'h00000000_AAAA5555_000000F0_11111111);
      check("rst_ready",   128'({bus.awready, bus.wready, bus.bvalid}), 128'(3'b110));
      check("rst_outputs", 128'({pulse, wr_stb}), 128'h0);
      #2 rst = 1'b0;
      idle(2);
      check("ro_follow", 128'(regs[95:64]), 128'(32'hCAFE0002));

      // simultaneous AW and W, full strobe
      axi_write(32'h0, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      check("s1_reg0", 128'(r_regs[31:0]), 128'(32'hDEADBEEF));
      check("s1_resp", 128'(r_resp), 128'(2'b00));
      check("s1_stb",  128'(r_stb), 128'(4'b0001));

      // AW three cycles before W, partial strobe, B held off 5 cycles
      axi_write(32'h0, 32'h12345678, 4'h3, 0, 3, 5);
      check("s2_state", 128'(mid_state), 128'(2'd1));
      check("s2_reg0",  128'(r_regs[31:0]), 128'(32'hDEAD5678));
      check("s2_resp",  128'(r_resp), 128'(2'b00));
      check("s2_bcyc",  128'(b_cycles), 128'(6));

      // low address bits ignored: addr 0x3 still hits register 0, byte 2 only
      axi_write(32'h3, 32'h00AB0000, 4'h4, 0, 0, 0);
      check("s3_reg0", 128'(r_regs[31:0]), 128'(32'hDEAB5678));
      check("s3_stb",  128'(r_stb), 128'(4'b0001));

      // RO register write rejected
      axi_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
      check("s4_resp", 128'(r_resp), 128'(2'b10));
      check("s4_stb",  128'(r_stb), 128'(4'b0000));
      check("s4_regs", 128'({r_regs[95:64], r_regs[31:0]}), 128'({32'hCAFE0002, 32'hDEAB5678}));

      // out-of-range write rejected, W ahead of AW
      axi_write(32'h10, 32'hFFFFFFFF, 4'hF, 2, 0, 0);
      check("s5_state", 128'(mid_state), 128'(2'd2));
      check("s5_resp",  128'(r_resp), 128'(2'b10));
      check("s5_stb",   128'(r_stb), 128'(4'b0000));
      check("s5_reg1",  128'(r_regs[63:32]), 128'(32'h000000F0));

      // W1C: sticky set, write-1 clear, then set wins over a coincident clear
      hw_set[32] = 1'b1;
      idle(1);
      hw_set[32] = 1'b0;
      idle(2);
      check("w1c_set", 128'(regs[63:32]), 128'(32'h000000F1));
      axi_write(32'h4, 32'h00000001, 4'h1, 0, 0, 0);
      check("w1c_clr",     128'(r_regs[63:32]), 128'(32'h000000F0));
      check("w1c_clr_stb", 128'(r_stb), 128'(4'b0010));
      hw_set[32] = 1'b1;
      axi_write(32'h4, 32'h00000001, 4'h1, 0, 0, 0);
      check("w1c_win", 128'(r_regs[63:32]), 128'(32'h000000F1));
      hw_set[32] = 1'b0;
      idle(2);
      check("w1c_sticky", 128'(regs[63:32]), 128'(32'h000000F1));

      // W1P: one-cycle pulse, register reads zero
      axi_write(32'hC, 32'h00000005, 4'hF, 0, 0, 2);
      check("w1p_pulse",  128'(r_pulse[99:96]), 128'(4'b0101));
      check("w1p_pulse2", 128'(r_pulse2[127:96]), 128'(32'h0));
      check("w1p_reg",    128'(r_regs[127:96]), 128'(32'h0));
      check("w1p_stb",    128'(r_stb), 128'(4'b1000));

      // reset while W is held in WAIT_AW abandons the transaction
      @(negedge clk);
      bus.wvalid = 1'b1; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
      @(negedge clk);
      bus.wvalid = 1'b0;
      check("ra_state", 128'(fsm_state), 128'(2'd2));
      #2 rst = 1'b1;
      @(negedge clk);
      check("ra_idle", 128'({fsm_state, bus.bvalid}), 128'(3'b000));
      check("ra_regs", regs, 128'h00000000_AAAA5555_000000F0_11111111);
      #2 rst = 1'b0;
      idle(2);
      check("ra_nob", 128'(bus.bvalid), 128'(1'b0));
      axi_write(32'h0, 32'h00000001, 4'h1, 0, 0, 0);
      check("ra_after", 128'(r_regs[31:0]), 128'(32'h11111101));
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
